// File: rtl/wb_slave_router.sv
// Wishbone address router: forwards one master transfer to either the user slave
// or the debug slave, with a per-transfer ack timeout and a saturating error count.
module wb_slave_router #(
    parameter logic [28:0] DEBUG_BASE = 29'h601FFFF,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        user_cyc_o,
    output logic        user_stb_o,
    input  logic        user_ack_i,
    input  logic [31:0] user_dat_i,
    output logic        debug_cyc_o,
    output logic        debug_stb_o,
    input  logic        debug_ack_i,
    input  logic [31:0] debug_dat_i,
    output logic        timeout_o,
    output logic [7:0]  err_cnt_o,
    output logic [1:0]  fsm_state
);

    // Handshake: a request is wbs_cyc_i & wbs_stb_i held until wbs_ack_o is seen;
    // slave acks count only from the selected slave while its strobe is high.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        USER  = 2'd1,
        DEBUG = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counter is 0 in the first strobe cycle, so TIMEOUT-2 marks the last one.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

    state_t      state;
    logic [7:0]  cnt;
    logic        req;
    logic        is_debug;
    logic        slave_ack;
    logic [31:0] slave_dat;
    logic        unused_adr;

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign is_debug   = (wbs_adr_i[31:3] == DEBUG_BASE);
    assign unused_adr = ^wbs_adr_i[2:0];
    assign fsm_state  = state;

    always_comb begin
        slave_ack = 1'b0;
        slave_dat = 32'h0;
        if (state == USER) begin
            slave_ack = user_ack_i;
            slave_dat = user_dat_i;
        end else if (state == DEBUG) begin
            slave_ack = debug_ack_i;
            slave_dat = debug_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state       <= IDLE;
            cnt         <= 8'h0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= 32'h0;
            user_cyc_o  <= 1'b0;
            user_stb_o  <= 1'b0;
            debug_cyc_o <= 1'b0;
            debug_stb_o <= 1'b0;
            timeout_o   <= 1'b0;
            err_cnt_o   <= 8'h0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= 32'h0;
                    if (req) begin
                        cnt <= 8'h0;
                        if (is_debug) begin
                            state       <= DEBUG;
                            debug_cyc_o <= 1'b1;
                            debug_stb_o <= 1'b1;
                        end else begin
                            state      <= USER;
                            user_cyc_o <= 1'b1;
                            user_stb_o <= 1'b1;
                        end
                    end
                end
                USER, DEBUG: begin
                    // Priority: master abort, then slave ack, then timeout.
                    if (!req) begin
                        state       <= IDLE;
                        user_cyc_o  <= 1'b0;
                        user_stb_o  <= 1'b0;
                        debug_cyc_o <= 1'b0;
                        debug_stb_o <= 1'b0;
                    end else if (slave_ack) begin
                        state       <= RESP;
                        wbs_ack_o   <= 1'b1;
                        wbs_dat_o   <= slave_dat;
                        user_cyc_o  <= 1'b0;
                        user_stb_o  <= 1'b0;
                        debug_cyc_o <= 1'b0;
                        debug_stb_o <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= RESP;
                        wbs_ack_o   <= 1'b1;
                        wbs_dat_o   <= ERR_DATA;
                        timeout_o   <= 1'b1;
                        user_cyc_o  <= 1'b0;
                        user_stb_o  <= 1'b0;
                        debug_cyc_o <= 1'b0;
                        debug_stb_o <= 1'b0;
                        if (err_cnt_o != 8'hFF) begin
                            err_cnt_o <= err_cnt_o + 8'h1;
                        end
                    end else begin
                        cnt <= cnt + 8'h1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= 32'h0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_router.sv
// Randomized bench for wb_slave_router: each transfer's outcome is resolved from
// the earliest of abort / ack / timeout and compared cycle by cycle.
module tb_wb_slave_router;

    localparam logic [28:0] DEBUG_BASE = 29'h601FFFF;
    localparam int          TIMEOUT    = 16;
    localparam logic [31:0] ERR_DATA   = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0;
    logic [31:0] adr = 32'h0;
    logic        ack;
    logic [31:0] dat;
    logic        user_cyc, user_stb, debug_cyc, debug_stb;
    logic        user_ack = 1'b0, debug_ack = 1'b0;
    logic [31:0] user_dat = 32'h0, debug_dat = 32'h0;
    logic        timeout;
    logic [7:0]  err_cnt;
    logic [1:0]  fsm_state;

    int n_chk = 0;
    int n_bad = 0;
    int exp_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wb_slave_router #(
        .DEBUG_BASE(DEBUG_BASE), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat),
        .user_cyc_o(user_cyc), .user_stb_o(user_stb),
        .user_ack_i(user_ack), .user_dat_i(user_dat),
        .debug_cyc_o(debug_cyc), .debug_stb_o(debug_stb),
        .debug_ack_i(debug_ack), .debug_dat_i(debug_dat),
        .timeout_o(timeout), .err_cnt_o(err_cnt), .fsm_state(fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ack"}, {31'h0, ack}, 32'h0);
        check({tag, " dat"}, dat, 32'h0);
        check({tag, " ustb"}, {30'h0, user_cyc, user_stb}, 32'h0);
        check({tag, " dstb"}, {30'h0, debug_cyc, debug_stb}, 32'h0);
        check({tag, " tmo"}, {31'h0, timeout}, 32'h0);
        check({tag, " err"}, {24'h0, err_cnt}, exp_err);
    endtask

    // ka: cycle the selected slave acks (0 = never); d: cycle the master drops (0 = never).
    // Other slave acks randomly throughout and must be ignored.
    task automatic run_txn(input logic [31:0] a, input int ka, input int d, input logic [31:0] rdat);
        bit   to_dbg;
        int   end_c, kind;
        int   drop_sel;
        bit   on;
        logic [31:0] exp_d;
        to_dbg   = (a[31:3] == DEBUG_BASE);
        drop_sel = $urandom_range(0, 2);
        end_c = TIMEOUT - 1;
        kind  = 2;
        if (ka != 0 && ka <= end_c) begin end_c = ka; kind = 1; end
        if (d != 0 && d <= end_c)   begin end_c = d;  kind = 0; end
        if (kind == 1) exp_q.push_back(rdat);
        else if (kind == 2) exp_q.push_back(ERR_DATA);

        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; adr = a;
        user_ack  = to_dbg ? 1'($urandom_range(0, 1)) : 1'b0;
        debug_ack = to_dbg ? 1'b0 : 1'($urandom_range(0, 1));
        user_dat  = $urandom; debug_dat = $urandom;
        @(negedge clk);
        check_idle("req0");

        for (int c = 1; c <= end_c + 1; c++) begin
            @(posedge clk); #1;
            on  = !(d != 0 && c >= d);
            cyc = on || (drop_sel == 1);
            stb = on || (drop_sel == 0);
            if (to_dbg) begin
                debug_ack = (c == ka);
                debug_dat = (c == ka) ? rdat : $urandom;
                user_ack  = 1'($urandom_range(0, 1));
                user_dat  = $urandom;
            end else begin
                user_ack  = (c == ka);
                user_dat  = (c == ka) ? rdat : $urandom;
                debug_ack = 1'($urandom_range(0, 1));
                debug_dat = $urandom;
            end
            if (kind == 2 && c == end_c + 1 && exp_err < 255) exp_err++;
            @(negedge clk);
            check("ustb", {30'h0, user_cyc, user_stb},   (!to_dbg && c <= end_c) ? 32'h3 : 32'h0);
            check("dstb", {30'h0, debug_cyc, debug_stb}, ( to_dbg && c <= end_c) ? 32'h3 : 32'h0);
            check("ack", {31'h0, ack}, (c == end_c + 1 && kind != 0) ? 32'h1 : 32'h0);
            check("tmo", {31'h0, timeout}, (c == end_c + 1 && kind == 2) ? 32'h1 : 32'h0);
            check("err", {24'h0, err_cnt}, exp_err);
            if (c == end_c + 1 && kind != 0 && exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                check("rdat", dat, exp_d);
            end else begin
                check("dat0", dat, 32'h0);
            end
        end

        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        user_ack = 1'($urandom_range(0, 1)); debug_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_idle("post");
        user_ack = 1'b0; debug_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int ka, d;

        #12;
        check_idle("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rel");

        run_txn(32'h300FFFF8, 3, 0, 32'h12345678);
        run_txn(32'h30000004, 0, 0, 32'h0);
        run_txn(32'h30000004, TIMEOUT - 1, 0, 32'hCAFEF00D);
        run_txn(32'h300FFFF8, TIMEOUT - 1, 0, 32'h0BADC0DE);
        run_txn(32'h300FFFF8, 5, 2, 32'h11111111);
        run_txn(32'h300FFFFC, 1, 0, 32'hA5A5A5A5);
        run_txn(32'h00000010, 1, 1, 32'h22222222);
        run_txn(32'h00000010, TIMEOUT, 0, 32'h33333333);

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = {DEBUG_BASE, 3'($urandom_range(0, 7))};
            ka = $urandom_range(0, TIMEOUT + 2);
            d  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT) : 0;
            run_txn(a, ka, d, $urandom);
        end

        for (int i = 0; i < 300; i++) begin
            run_txn($urandom_range(0, 1) ? 32'h300FFFF8 : 32'h40000000, 0, 0, 32'h0);
        end
        check("sat", {24'h0, err_cnt}, 32'hFF);

        // Reset in the middle of a debug transfer.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; adr = 32'h300FFFF8;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        exp_err = 0;
        #1;
        check_idle("arst");
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; debug_ack = 1'b1; debug_dat = 32'h12345678;
        @(negedge clk);
        check_idle("arst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_idle("arst_after");
            @(posedge clk); #1;
            debug_ack = (c == 0);
        end
        debug_ack = 1'b0;
        run_txn(32'h30000004, 2, 0, 32'h55AA55AA);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
